// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI sender and receiver blocks.
//   spi_state_e     : link-level state (IDLE, ACTIVE)
//   SYNC_STAGES     : depth of the pin synchronizers
//   sample_on_rise  : 1 when data is sampled on the rising sck edge for the
//                     given cpol/cpha mode, 0 when it is sampled on the falling
//                     edge
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int SYNC_STAGES = 2;

  // Modes 0 and 3 sample on the rising edge; modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return ~(cpol ^ cpha);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Single-bit multi-flop synchronizer bringing an asynchronous pin into the
// clk domain.
//   RESET_VAL : value every stage takes during reset (the pin's idle level)
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (last stage)
// -----------------------------------------------------------------------------
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the pin through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/spi_receiver.sv
// -----------------------------------------------------------------------------
// spi_receiver
// SPI slave-side receiver. sck, mosi and cs_n are synchronized into clk, the
// mode-dependent sampling edge is detected on the synchronized sck, and
// DATA_WIDTH-bit words are deserialized and offered on a valid/ready port.
//
// Optional feature (compile-time macro SPI_RX_FRAME_ERR_EN):
//   adds output frame_err, a one-cycle pulse when cs_n deasserts with a
//   partially received word.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   lsb_first   : 1 = first bit on the wire is bit 0
//   cpol, cpha  : SPI mode (must be stable while busy)
//   cs_n, sck, mosi : raw SPI pins (asynchronous)
//   rx_ready    : consumer accepts rxb this cycle
//   rxb         : received word
//   rx_valid    : rxb holds an unconsumed word
//   overrun     : one-cycle pulse, a completed word was dropped
//   frame_err   : (SPI_RX_FRAME_ERR_EN only) partial word discarded
//   busy        : receiver is inside a cs_n frame
// -----------------------------------------------------------------------------
module spi_receiver
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsb_first,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rxb,
  output logic                  rx_valid,
  output logic                  overrun,
`ifdef SPI_RX_FRAME_ERR_EN
  output logic                  frame_err,
`endif
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic cs_n_s2_s;
  logic sck_s2_s;
  logic mosi_s2_s;
  logic sck_s3_r;

  spi_state_e            state_r;
  logic [CW-1:0]         cnt_r;
  logic [DATA_WIDTH-1:0] shift_r;

  logic                  rise_s;
  logic                  fall_s;
  logic                  sample_s;
  logic                  last_bit_s;
  logic                  word_done_s;
  logic [DATA_WIDTH-1:0] shift_next_s;

  // cs_n idles high, so its chain resets to 1 to avoid a false frame start.
  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_n_s2_s)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sck),
    .q     (sck_s2_s)
  );

  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi),
    .q     (mosi_s2_s)
  );

  // Third sck stage, used only for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_s3_r <= 1'b0;
    end else begin
      sck_s3_r <= sck_s2_s;
    end
  end

  // Edge detection, sample-edge selection and next shift-register value.
  always_comb begin
    rise_s     = sck_s2_s & ~sck_s3_r;
    fall_s     = ~sck_s2_s & sck_s3_r;
    sample_s   = 1'b0;
    if (sample_on_rise(cpol, cpha)) begin
      sample_s = rise_s;
    end else begin
      sample_s = fall_s;
    end
    shift_next_s = shift_r;
    if (lsb_first) begin
      shift_next_s = {mosi_s2_s, shift_r[DATA_WIDTH-1:1]};
    end else begin
      shift_next_s = {shift_r[DATA_WIDTH-2:0], mosi_s2_s};
    end
    last_bit_s  = (cnt_r == CNT_LAST);
    // A deasserting cs_n takes priority over a coincident sample edge.
    word_done_s = (state_r == ACTIVE) & ~cs_n_s2_s & sample_s & last_bit_s;
  end

  // Receiver FSM with deserializer, output word register and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      shift_r   <= {DATA_WIDTH{1'b0}};
      rxb       <= {DATA_WIDTH{1'b0}};
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      overrun   <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          cnt_r   <= CNT_ZERO;
          shift_r <= {DATA_WIDTH{1'b0}};
          if (!cs_n_s2_s) begin
            state_r <= ACTIVE;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_n_s2_s) begin
            // Frame ended: drop any partial word.
            state_r <= IDLE;
            busy    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            shift_r <= {DATA_WIDTH{1'b0}};
`ifdef SPI_RX_FRAME_ERR_EN
            frame_err <= (cnt_r != CNT_ZERO);
`endif
          end else begin
            state_r <= ACTIVE;
            busy    <= 1'b1;
            if (sample_s) begin
              if (last_bit_s) begin
                cnt_r   <= CNT_ZERO;
                shift_r <= {DATA_WIDTH{1'b0}};
              end else begin
                cnt_r   <= cnt_r + CNT_ONE;
                shift_r <= shift_next_s;
              end
            end else begin
              cnt_r   <= cnt_r;
              shift_r <= shift_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= CNT_ZERO;
          shift_r <= {DATA_WIDTH{1'b0}};
        end
      endcase

      // Output register: a completed word loads unless an unconsumed word
      // would be overwritten, in which case the new word is dropped.
      if (word_done_s) begin
        if (!rx_valid || rx_ready) begin
          rxb      <= shift_next_s;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule

// File: tb/tb_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_receiver
// Self-checking bench for spi_receiver (DATA_WIDTH = 8). A task-level SPI
// master drives the pins; expected words are computed from the wire bit
// order and the mode rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_receiver;

  localparam int W = 8;
  localparam int H = 4;   // sck half period in clk cycles

  logic         clk;
  logic         rst_n;
  logic         lsb_first;
  logic         cpol;
  logic         cpha;
  logic         cs_n;
  logic         sck;
  logic         mosi;
  logic         rx_ready;
  logic [W-1:0] rxb;
  logic         rx_valid;
  logic         overrun;
  logic         busy;
`ifdef SPI_RX_FRAME_ERR_EN
  logic         frame_err;
`endif

  int checks = 0;
  int errors = 0;

  spi_receiver #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsb_first (lsb_first),
    .cpol      (cpol),
    .cpha      (cpha),
    .cs_n      (cs_n),
    .sck       (sck),
    .mosi      (mosi),
    .rx_ready  (rx_ready),
    .rxb       (rxb),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
`ifdef SPI_RX_FRAME_ERR_EN
    .frame_err (frame_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- monitor (sole writer of observation state) -------------
  int           cyc = 0;
  logic [W-1:0] got_q[$];
  int           ovr_pulses = 0;
  int           ovr_hi = 0;
  logic         ovr_prev = 1'b0;
  int           fe_pulses = 0;
  logic         fe_prev = 1'b0;
  logic         val_prev = 1'b0;
  int           val_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rxb);
    if (overrun) ovr_hi++;
    if (overrun && !ovr_prev) ovr_pulses++;
    ovr_prev = overrun;
    if (rx_valid && !val_prev) val_rise_cyc = cyc;
    val_prev = rx_valid;
`ifdef SPI_RX_FRAME_ERR_EN
    if (frame_err && !fe_prev) fe_pulses++;
    fe_prev = frame_err;
`endif
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model and SPI master -------------------------
  int edge_cyc = 0;   // cycle of the most recent driven sample edge

  // Word assembled from the wire bits (pat[i] = i-th bit on the wire).
  function automatic logic [W-1:0] model_word(input logic [31:0] pat, input logic lsb);
    int acc = 0;
    for (int i = 0; i < W; i++) begin
      if (lsb) acc = acc + (pat[i] ? (1 << i) : 0);
      else     acc = acc * 2 + (pat[i] ? 1 : 0);
    end
    return acc[W-1:0];
  endfunction

  // Wire order for transmitting a word.
  function automatic logic [31:0] pin_of(input logic [W-1:0] w, input logic lsb);
    logic [31:0] p = 32'd0;
    for (int i = 0; i < W; i++) p[i] = lsb ? w[i] : w[W-1-i];
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    cpol = pol; cpha = pha; lsb_first = lsb;
    sck = pol;
    tick(4);
  endtask

  task automatic frame_begin();
    sck  = cpol;
    tick(4);
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    cs_n = 1'b1;
    tick(6);
  endtask

  task automatic send_bits(input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      if (!cpha) begin
        mosi = pat[i];
        tick(H);
        sck = ~cpol;
        edge_cyc = cyc;
        tick(H);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = pat[i];
        tick(H);
        sck = cpol;
        edge_cyc = cyc;
        tick(H);
      end
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    send_bits(W, pin_of(w, lsb_first));
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; rx_ready = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    checks++; if (rxb !== 8'h00)     begin errors++; $display("FAIL reset_rxb got %h exp 00", rxb); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_mode0();
    int o0, g0;
    set_mode(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    o0 = ovr_pulses; g0 = got_q.size();
    frame_begin();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy got %b exp 1", busy); end
    send_word(8'hA5);
    frame_end();
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL m0_valid got %b exp 1", rx_valid); end
    checks++; if (rxb !== 8'hA5) begin errors++; $display("FAIL m0_rxb got %h exp a5", rxb); end
    checks++; if (val_rise_cyc - edge_cyc !== 3) begin errors++; $display("FAIL m0_latency got %0d exp 3", val_rise_cyc - edge_cyc); end
    checks++; if (ovr_pulses - o0 !== 0) begin errors++; $display("FAIL m0_overrun got %0d exp 0", ovr_pulses - o0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end got %b exp 0", busy); end
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0; tick(1);
    checks++; if (got_q.size() - g0 !== 1) begin errors++; $display("FAIL m0_count got %0d exp 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'hA5) begin errors++; $display("FAIL m0_word got %h exp a5", got_q[g0]); end
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m0_consumed got %b exp 0", rx_valid); end
  endtask

  task automatic test_mode3_lsb();
    set_mode(1'b1, 1'b1, 1'b1);
    rx_ready = 1'b0;
    frame_begin();
    send_bits(W, 32'h0000_0001);
    frame_end();
    checks++; if (rxb !== model_word(32'h1, 1'b1)) begin errors++; $display("FAIL m3_rxb got %h exp %h", rxb, model_word(32'h1, 1'b1)); end
    checks++; if (rxb !== 8'h01) begin errors++; $display("FAIL m3_rxb_const got %h exp 01", rxb); end
    rx_ready = 1'b1; tick(2); rx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int g0;
    set_mode(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b1;
    g0 = got_q.size();
    frame_begin();
    send_word(8'h3C);
    send_word(8'hC3);
    frame_end();
    checks++; if (got_q.size() - g0 !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h3C)   begin errors++; $display("FAIL b2b_w0 got %h exp 3c", got_q[g0]); end
      checks++; if (got_q[g0+1] !== 8'hC3) begin errors++; $display("FAIL b2b_w1 got %h exp c3", got_q[g0+1]); end
    end
  endtask

  task automatic test_overrun();
    int o0, h0, g0;
    set_mode(1'b0, 1'b1, 1'b0);
    rx_ready = 1'b0;
    o0 = ovr_pulses; h0 = ovr_hi;
    frame_begin();
    send_word(8'h11);
    send_word(8'h22);
    frame_end();
    checks++; if (rxb !== 8'h11) begin errors++; $display("FAIL ovr_rxb got %h exp 11", rxb); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
    checks++; if (ovr_pulses - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got %0d exp 1", ovr_pulses - o0); end
    checks++; if (ovr_hi - h0 !== 1) begin errors++; $display("FAIL ovr_width got %0d exp 1", ovr_hi - h0); end
    g0 = got_q.size();
    rx_ready = 1'b1; tick(3); rx_ready = 1'b0;
    checks++; if (got_q.size() - g0 !== 1) begin errors++; $display("FAIL ovr_count got %0d exp 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h11) begin errors++; $display("FAIL ovr_word got %h exp 11", got_q[g0]); end
    end
  endtask

  task automatic test_partial();
    int g0, f0;
    set_mode(1'b1, 1'b0, 1'b0);
    rx_ready = 1'b1;
    g0 = got_q.size(); f0 = fe_pulses;
    frame_begin();
    send_bits(5, 32'h0000_001F);
    frame_end();
    frame_begin();
    send_word(8'h5A);
    frame_end();
    checks++; if (got_q.size() - g0 !== 1) begin errors++; $display("FAIL part_count got %0d exp 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'h5A) begin errors++; $display("FAIL part_word got %h exp 5a", got_q[g0]); end
    end
`ifdef SPI_RX_FRAME_ERR_EN
    checks++; if (fe_pulses - f0 !== 1) begin errors++; $display("FAIL part_frame_err got %0d exp 1", fe_pulses - f0); end
`else
    checks++; if (fe_pulses - f0 !== 0) begin errors++; $display("FAIL part_frame_err got %0d exp 0", fe_pulses - f0); end
`endif
  endtask

  task automatic test_reset_mid();
    int g0;
    set_mode(1'b0, 1'b0, 1'b0);
    rx_ready = 1'b0;
    frame_begin();
    send_word(8'h77);
    send_bits(4, 32'h0000_000F);
    checks++; if (rxb !== 8'h77) begin errors++; $display("FAIL rmid_pre got %h exp 77", rxb); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (rxb !== 8'h00)     begin errors++; $display("FAIL rmid_rxb got %h exp 00", rxb); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", rx_valid); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
    checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL rmid_overrun got %b exp 0", overrun); end
    cs_n = 1'b1; sck = cpol; mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    rx_ready = 1'b1;
    g0 = got_q.size();
    frame_begin();
    send_word(8'hF0);
    frame_end();
    checks++; if (got_q.size() - g0 !== 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", got_q.size() - g0); end
    else begin
      checks++; if (got_q[g0] !== 8'hF0) begin errors++; $display("FAIL rmid_word got %h exp f0", got_q[g0]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [31:0]  pat;
    int           g0, o0, nw;
    g0 = got_q.size(); o0 = ovr_pulses;
    rx_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      set_mode(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      nw = $urandom_range(3, 1);
      frame_begin();
      for (int k = 0; k < nw; k++) begin
        pat = $urandom;
        exp_q.push_back(model_word(pat, lsb_first));
        send_bits(W, pat);
      end
      frame_end();
    end
    checks++; if (got_q.size() - g0 !== exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got_q.size() - g0, exp_q.size()); end
    else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++; if (got_q[g0+k] !== exp_q[k]) begin errors++; $display("FAIL rnd_word%0d got %h exp %h", k, got_q[g0+k], exp_q[k]); end
      end
    end
    checks++; if (ovr_pulses - o0 !== 0) begin errors++; $display("FAIL rnd_overrun got %0d exp 0", ovr_pulses - o0); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_back_to_back();
    test_overrun();
    test_partial();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
